exponential_block_16: RTL and testbench

Second stage of the 16-bit softmax datapath. Consumes the stream of downscaled values (Zi − Zmax, signed Q7.8, ≤ 0) from the downscale stage and produces e^(Zi − Zmax) for each element as unsigned Q1.15. It also accumulates the running sum of all exponentials for the downstream divider stage. A fixed 3-stage pipeline computes e^x = 2^(x·log2e), with a linear 2^-f mantissa approximation and a barrel shift.

---
 rtl/exponential_block_16.sv | 148 ++++++++++++++
 tb/tb_exponential_block_16.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/exponential_block_16.sv
// Softmax stage 2: e^x for x = Zi - Zmax (Q7.8, <= 0) as Q1.15, with a running sum.
// Optional accumulator enabled by defining EXP_SUM_EN; otherwise exp_sum_o is tied to 0.
module exponential_block_16 #(
    parameter int unsigned data_size = 16,
    parameter int unsigned sum_size  = 24
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 downscale_data_valid_i,
    input  logic [data_size-1:0] downscale_data_i,
    input  logic [7:0]           downscale_number_of_data_i,
    input  logic                 downscale_done_i,
    output logic                 exp_data_valid_o,
    output logic [data_size-1:0] exp_data_o,
    output logic [sum_size-1:0]  exp_sum_o,
    output logic [7:0]           exp_number_of_data_o,
    output logic                 exp_done_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e      state_q, state_d;
    logic [7:0]  in_count_q, in_count_d;
    logic [7:0]  out_count_q, out_count_d;
    logic [7:0]  num_q, num_d;
    logic        done_q, done_d;
    logic        v1_q, v2_q, v3_q;
    logic [16:0] u1_q, u1_d;
    logic [8:0]  n2_q, n2_d;
    logic [15:0] m2_q, m2_d;
    logic [15:0] y3_q, y3_d;
    logic        accept;

    logic [15:0] x_clamp;
    logic [15:0] a_mag;
    logic [24:0] prod;
    logic [15:0] y_shift;

    // Inputs are dropped in DONE and once all N have been taken in DRAIN
    assign accept = downscale_data_valid_i &&
                    ((state_q == StIdle) || (state_q == StRun) ||
                     ((state_q == StDrain) && (in_count_q != num_q)));

    always_comb begin
        x_clamp = (!downscale_data_i[15] && (downscale_data_i != '0)) ? '0 : downscale_data_i;
        a_mag   = -x_clamp;
        prod    = {9'd0, a_mag} * 25'd369;
        // Only p[24:8] is consumed downstream, so only those bits are held in S1
        u1_d    = prod[24:8];
        n2_d    = u1_q[16:8];
        m2_d    = 16'h8000 - {2'b00, u1_q[7:0], 6'd0};
        y_shift = (|n2_q[8:4]) ? 16'd0 : (m2_q >> n2_q[3:0]);
        y3_d    = v2_q ? y_shift : 16'd0;
    end

    always_comb begin
        state_d     = state_q;
        num_d       = num_q;
        in_count_d  = in_count_q + 8'(accept);
        out_count_d = out_count_q + 8'(v2_q);
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StRun;
                    if (downscale_done_i) begin
                        state_d = StDrain;
                        num_d   = downscale_number_of_data_i;
                    end
                end
            end
            StRun: begin
                if (downscale_done_i) begin
                    state_d = StDrain;
                    num_d   = downscale_number_of_data_i;
                end
            end
            StDrain: begin
                if ((out_count_q == num_q) && (num_q != 8'd0) && !v1_q && !v2_q) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StDone;
            default: state_d = StIdle;
        endcase
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            num_q       <= '0;
            in_count_q  <= '0;
            out_count_q <= '0;
            done_q      <= 1'b0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            u1_q        <= '0;
            n2_q        <= '0;
            m2_q        <= '0;
            y3_q        <= '0;
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            done_q      <= done_d;
            v1_q        <= accept;
            v2_q        <= v1_q;
            v3_q        <= v2_q;
            u1_q        <= u1_d;
            n2_q        <= n2_d;
            m2_q        <= m2_d;
            y3_q        <= y3_d;
        end
    end

`ifdef EXP_SUM_EN
    logic [sum_size-1:0] sum_q, sum_d;
    logic [sum_size:0]   sum_ext;

    always_comb begin
        sum_ext = {1'b0, sum_q} + {{(sum_size + 1 - 16){1'b0}}, y_shift};
        sum_d   = sum_q;
        if (v2_q) begin
            sum_d = sum_ext[sum_size] ? '1 : sum_ext[sum_size-1:0];
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign exp_sum_o = sum_q;
`else
    assign exp_sum_o = '0;
`endif

    assign exp_data_valid_o     = v3_q;
    assign exp_data_o           = data_size'(y3_q);
    assign exp_number_of_data_o = num_q;
    assign exp_done_o           = done_q;

endmodule

// File: tb/tb_exponential_block_16.sv
// Randomized self-checking bench for exponential_block_16 with an arithmetic reference model.
module tb_exponential_block_16;

`ifdef EXP_SUM_EN
    localparam bit SumEn = 1'b1;
`else
    localparam bit SumEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv = 1'b0;
    logic [15:0] dd = '0;
    logic [7:0]  dn = '0;
    logic        ddone = 1'b0;
    logic        ev;
    logic [15:0] ed;
    logic [23:0] es;
    logic [7:0]  en;
    logic        edone;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int q_y[$];
    int q_due[$];
    int msum = 0;
    int out_cnt = 0;
    int last_valid_cyc = -10;

    exponential_block_16 #(.data_size(16), .sum_size(24)) dut (
        .clock_i                    (clk),
        .reset_i                    (rst),
        .downscale_data_valid_i     (dv),
        .downscale_data_i           (dd),
        .downscale_number_of_data_i (dn),
        .downscale_done_i           (ddone),
        .exp_data_valid_o           (ev),
        .exp_data_o                 (ed),
        .exp_sum_o                  (es),
        .exp_number_of_data_o       (en),
        .exp_done_o                 (edone)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    // e^x = 2^(x*log2e) with a linear mantissa, computed from plain integer arithmetic
    function automatic int exp_model(input logic [15:0] d);
        int x, a, u, n, f, m;
        x = int'($signed(d));
        if (x > 0) x = 0;
        a = -x;
        u = (a * 369) / 256;
        n = u / 256;
        f = u % 256;
        m = 32768 - 64 * f;
        return (n >= 16) ? 0 : m / (1 << n);
    endfunction

    function automatic logic [15:0] rand_val();
        int r;
        case ($urandom_range(0, 4))
            0: r = -int'($urandom_range(0, 32767));
            1: r = -int'($urandom_range(0, 2048));
            2: r = int'($urandom_range(1, 32767));
            3: r = -32768;
            default: r = 0;
        endcase
        return 16'(r);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (ev) begin
                if (q_y.size() == 0) begin
                    check_eq("spurious_valid", 32'(ev), 32'd0);
                end else begin
                    int ey, due;
                    ey = q_y.pop_front();
                    due = q_due.pop_front();
                    msum = (msum + ey > 32'hFFFFFF) ? 32'hFFFFFF : msum + ey;
                    check_eq("exp_data", 32'(ed), 32'(ey));
                    check_eq("latency", 32'(cyc), 32'(due));
                    check_eq("running_sum", 32'(es), SumEn ? 32'(msum) : 32'd0);
                    out_cnt++;
                    last_valid_cyc = cyc;
                end
            end else begin
                check_eq("data_zero_idle", 32'(ed), 32'd0);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        dv = 1'b0;
        dd = '0;
        ddone = 1'b0;
        q_y.delete();
        q_due.delete();
        msum = 0;
        out_cnt = 0;
        last_valid_cyc = -10;
        #1;
        check_eq("rst_valid", 32'(ev), 32'd0);
        check_eq("rst_data", 32'(ed), 32'd0);
        check_eq("rst_sum", 32'(es), 32'd0);
        check_eq("rst_num", 32'(en), 32'd0);
        check_eq("rst_done", 32'(edone), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drive(input logic [15:0] d, input bit expect_out, input bit set_done);
        @(posedge clk);
        #1;
        dv = 1'b1;
        dd = d;
        if (set_done) ddone = 1'b1;
        if (expect_out) begin
            q_y.push_back(exp_model(d));
            q_due.push_back(cyc + 3);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            dv = 1'b0;
        end
    endtask

    task automatic wait_done(input int n);
        int t;
        idle(1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!edone && t < 200);
        check_eq("done_seen", 32'(edone), 32'd1);
        check_eq("out_count", 32'(out_cnt), 32'(n));
        check_eq("done_timing", 32'(cyc), 32'(last_valid_cyc + 1));
        check_eq("num_latched", 32'(en), 32'(n));
        check_eq("final_sum", 32'(es), SumEn ? 32'(msum) : 32'd0);
        check_eq("queue_empty", 32'(q_y.size()), 32'd0);
    endtask

    initial begin
        // Directed: three values on consecutive cycles, done afterwards
        do_reset();
        dn = 8'd3;
        drive(16'h0000, 1'b1, 1'b0);
        drive(16'hFF00, 1'b1, 1'b0);
        drive(16'hFF80, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        dv = 1'b0;
        ddone = 1'b1;
        wait_done(3);
        check_eq("s1_sum_const", 32'(es), SumEn ? 32'h0103E0 : 32'd0);

        // Deep negative input
        do_reset();
        dn = 8'd1;
        drive(16'hF800, 1'b1, 1'b1);
        wait_done(1);

        // Most negative and a positive (clamped) input
        do_reset();
        dn = 8'd2;
        drive(16'h8000, 1'b1, 1'b0);
        drive(16'h0100, 1'b1, 1'b1);
        wait_done(2);

        // done with N = 0 in IDLE must not finish
        do_reset();
        dn = 8'd0;
        @(posedge clk);
        #1;
        ddone = 1'b1;
        idle(5);
        @(negedge clk);
        check_eq("n0_no_done", 32'(edone), 32'd0);

        // Reset with two elements in flight
        do_reset();
        dn = 8'd4;
        drive(16'h0000, 1'b1, 1'b0);
        drive(16'hFF00, 1'b1, 1'b0);
        do_reset();
        repeat (6) begin
            @(negedge clk);
            check_eq("post_reset_valid", 32'(ev), 32'd0);
        end
        dn = 8'd1;
        drive(16'h0000, 1'b1, 1'b1);
        wait_done(1);

        // Randomized gapped streams, then a dropped extra valid
        for (int s = 0; s < 20; s++) begin
            int n;
            do_reset();
            n = $urandom_range(1, 12);
            dn = 8'(n);
            for (int i = 0; i < n; i++) begin
                idle($urandom_range(0, 3));
                drive(rand_val(), 1'b1, i == n - 1);
            end
            wait_done(n);
            drive(rand_val(), 1'b0, 1'b0);
            idle(6);
            @(negedge clk);
            check_eq("done_sticky", 32'(edone), 32'd1);
            check_eq("sum_stable", 32'(es), SumEn ? 32'(msum) : 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
